ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one simple dual-port RAM (one write port, one read port, 1-cycle registered read) between NUM requesters, e.g. game-state logic, input handler and display scanner.
- Independent round-robin arbitration on the write port and the read port.
- Returns read data to the winning requester with a valid strobe.
- Blocks same-cycle read/write to the same address; the RAM result for that case is undefined.

Parameters:
- NUM, 2, number of requesters (2..8)
- SIZE, 8, RAM word width
- DEPTH, 8, RAM entries; address width AW = $clog2(DEPTH)

Ports:
- clk  input  1  system clock; drives the RAM wclk and rclk
- rst_n  input  1  asynchronous active-low reset
- wr_req  input  NUM  per-requester write request, held until acked
- wr_addr  input  NUM*AW  packed write addresses, requester i at [i*AW +: AW]
- wr_data  input  NUM*SIZE  packed write data
- wr_ack  output  NUM  one-hot: write issued this cycle
- rd_req  input  NUM  per-requester read request, held until acked
- rd_addr  input  NUM*AW  packed read addresses
- rd_ack  output  NUM  one-hot: read address issued this cycle
- rd_valid  output  NUM  one-hot: rd_data belongs to requester i this cycle
- rd_data  output  SIZE  read data, shared by all requesters
- ram_waddr  output  AW  to RAM waddr
- ram_write_data  output  SIZE  to RAM write_data
- ram_write_en  output  1  to RAM write_en
- ram_raddr  output  AW  to RAM raddr
- ram_read_data  input  SIZE  from RAM read_data
- conflict_cnt  output  8  saturating count of reads deferred by address collision

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0
  - rd_valid = 0, rd_id = 0, conflict_cnt = 0
  - Combinational outputs follow the rules below with pointers at 0.
- Write arbitration (combinational):
  - Winner is the first i with wr_req[i]=1, searching from wr_ptr upward mod NUM.
  - wr_ack = onehot(winner). ram_write_en = |wr_req.
  - ram_waddr / ram_write_data = winner's fields. Both are 0 when there is no request.
- Write pointer: on any write grant, wr_ptr <= (winner+1) mod NUM at the clock edge. Otherwise it holds.
- Read arbitration (combinational):
  - Winner is selected the same way from rd_ptr. ram_raddr = winner's rd_addr, 0 when idle.
- Collision rule:
  - If ram_write_en=1 and the read winner's address equals ram_waddr, all rd_ack bits are 0 that cycle.
  - rd_ptr does not advance. conflict_cnt increments, saturating at 255.
  - The read is retried the next cycle. Writes are never stalled.
- Read grant (no collision):
  - rd_ack = onehot(winner).
  - At the edge: rd_ptr <= (winner+1) mod NUM, rd_id <= winner, rd_pending <= 1.
- Read return:
  - Cycle after rd_ack, rd_valid = onehot(rd_id) if rd_pending, else 0.
  - rd_data = ram_read_data, passed through combinationally and aligned with the RAM's 1-cycle latency.
  - Back-to-back reads give one rd_valid per cycle.
- Acks depend combinationally on req. Requesters must not form a combinational path from ack back to req.
- A requester may change its address/data only in the cycle after its ack.
- Simultaneous read and write from the same requester to different addresses are both granted in one cycle.
- Reset asserted mid-read: the pending rd_valid is dropped, and the RAM contents are whatever was written before reset.
- NUM=1 degenerates to a pass-through with the collision rule still applied.

Test Plan:
- Reset, then idle: all acks 0, rd_valid 0, ram_write_en 0, conflict_cnt 0.
- Fairness: wr_req=2'b11 held for 4 cycles -> wr_ack sequence 01,10,01,10. Same with rd_req -> rd_ack 01,10,01,10.
- Write then read: req0 writes 0xA5 to addr 3; next cycle req1 reads addr 3 -> rd_ack=10, then one cycle later rd_valid=10 with rd_data=0xA5.
- Collision: req0 writes addr 5 while req1 reads addr 5 -> rd_ack=00, conflict_cnt=1. Next cycle with no write -> rd_ack=10, and the following cycle returns the new value.
- Saturation: force 300 collisions -> conflict_cnt stays at 255.
- Reset mid-read: assert rst_n=0 the cycle after rd_ack -> rd_valid=0 and pointers 0. After release, wr_req=11 grants requester 0 first.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
// Bundles the requester-side handshake and the RAM-side bus of the
// ram_port_arbiter.
//   slave  : the arbiter (takes requests and RAM read data, drives acks,
//            RAM controls and conflict_cnt)
//   master : requesters plus RAM (the opposite directions)
// Per-requester fields are packed, requester i at [i*W +: W].
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
   parameter int NUM   = 2,
   parameter int SIZE  = 8,
   parameter int DEPTH = 8
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // requester side
   logic [NUM-1:0]      wr_req;
   logic [NUM*AW-1:0]   wr_addr;
   logic [NUM*SIZE-1:0] wr_data;
   logic [NUM-1:0]      wr_ack;
   logic [NUM-1:0]      rd_req;
   logic [NUM*AW-1:0]   rd_addr;
   logic [NUM-1:0]      rd_ack;
   logic [NUM-1:0]      rd_valid;
   logic [SIZE-1:0]     rd_data;

   // RAM side
   logic [AW-1:0]       ram_waddr;
   logic [SIZE-1:0]     ram_write_data;
   logic                ram_write_en;
   logic [AW-1:0]       ram_raddr;
   logic [SIZE-1:0]     ram_read_data;

   // status
   logic [7:0]          conflict_cnt;

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_read_data,
      output wr_ack, rd_ack, rd_valid, rd_data,
             ram_waddr, ram_write_data, ram_write_en, ram_raddr,
             conflict_cnt
   );

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_read_data,
      input  wr_ack, rd_ack, rd_valid, rd_data,
             ram_waddr, ram_write_data, ram_write_en, ram_raddr,
             conflict_cnt
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one simple dual-port RAM (1 write port, 1 read port with 1-cycle
// registered read) between NUM requesters. Write and read ports each have an
// independent round-robin arbiter. A read whose winning address matches the
// address being written in the same cycle is deferred (no rd_ack) and counted
// in a saturating 8-bit conflict counter; writes are never stalled.
// Ports:
//   clk   : system clock (also clocks the RAM)
//   rst_n : asynchronous active-low reset
//   bus   : ram_port_arbiter_if.slave -- requester handshakes, RAM bus,
//           conflict_cnt
// ---------------------------------------------------------------------------

// Round-robin pick: first requester at or above ptr_i (mod NUM).
module ram_port_arbiter_rr #(
   parameter int NUM = 2,
   parameter int PW  = 1
) (
   input  logic [NUM-1:0] req_i,
   input  logic [PW-1:0]  ptr_i,
   output logic           any_o,
   output logic [PW-1:0]  win_o,
   output logic [NUM-1:0] gnt_o
);
   always_comb begin
      int idx;
      idx   = 0;
      any_o = 1'b0;
      win_o = '0;
      // Walk offsets from farthest to nearest so the nearest request is the
      // last assignment and therefore the winner.
      for (int k = NUM - 1; k >= 0; k--) begin
         idx = (int'(ptr_i) + k) % NUM;
         if (req_i[idx]) begin
            any_o = 1'b1;
            win_o = PW'(idx);
         end
      end
      gnt_o = any_o ? (NUM'(1) << win_o) : '0;
   end
endmodule

module ram_port_arbiter #(
   parameter int NUM   = 2,
   parameter int SIZE  = 8,
   parameter int DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   ram_port_arbiter_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;

   // per-requester views of the packed request fields
   logic [NUM-1:0][AW-1:0]   wr_addr_a;
   logic [NUM-1:0][SIZE-1:0] wr_data_a;
   logic [NUM-1:0][AW-1:0]   rd_addr_a;

   assign wr_addr_a = bus.wr_addr;
   assign wr_data_a = bus.wr_data;
   assign rd_addr_a = bus.rd_addr;

   // state
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] rd_id_q,  rd_id_d;
   logic          rd_pend_q, rd_pend_d;
   logic [7:0]    cnt_q, cnt_d;

   // arbitration results
   logic           wr_any, rd_any;
   logic [PW-1:0]  wr_win, rd_win;
   logic [NUM-1:0] wr_gnt, rd_gnt;
   logic [AW-1:0]  waddr, raddr;
   logic           collide;

   ram_port_arbiter_rr #(.NUM(NUM), .PW(PW)) u_wr_rr (
      .req_i (bus.wr_req),
      .ptr_i (wr_ptr_q),
      .any_o (wr_any),
      .win_o (wr_win),
      .gnt_o (wr_gnt)
   );

   ram_port_arbiter_rr #(.NUM(NUM), .PW(PW)) u_rd_rr (
      .req_i (bus.rd_req),
      .ptr_i (rd_ptr_q),
      .any_o (rd_any),
      .win_o (rd_win),
      .gnt_o (rd_gnt)
   );

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] w);
      return (w == PW'(NUM - 1)) ? '0 : w + 1'b1;
   endfunction

   assign waddr   = wr_any ? wr_addr_a[wr_win] : '0;
   assign raddr   = rd_any ? rd_addr_a[rd_win] : '0;
   // Same-cycle read/write to one address gives undefined RAM read data,
   // so the read is held off and retried.
   assign collide = wr_any && rd_any && (raddr == waddr);

   // write port: always granted
   assign bus.wr_ack         = wr_gnt;
   assign bus.ram_write_en   = wr_any;
   assign bus.ram_waddr      = waddr;
   assign bus.ram_write_data = wr_any ? wr_data_a[wr_win] : '0;

   // read port: address goes to the RAM even when deferred; no ack then
   assign bus.ram_raddr = raddr;
   assign bus.rd_ack    = collide ? '0 : rd_gnt;

   // read return lines up with the RAM's registered output
   assign bus.rd_valid     = rd_pend_q ? (NUM'(1) << rd_id_q) : '0;
   assign bus.rd_data      = bus.ram_read_data;
   assign bus.conflict_cnt = cnt_q;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_id_d   = rd_id_q;
      rd_pend_d = 1'b0;
      cnt_d     = cnt_q;
      if (wr_any) wr_ptr_d = nxt(wr_win);
      if (rd_any && !collide) begin
         rd_ptr_d  = nxt(rd_win);
         rd_id_d   = rd_win;
         rd_pend_d = 1'b1;
      end
      if (collide && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rd_id_q   <= '0;
         rd_pend_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_id_q   <= rd_id_d;
         rd_pend_q <= rd_pend_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Drives the arbiter through directed scenarios and a random phase, with a
// behavioural RAM attached to the RAM-side bus and a reference model of the
// arbitration rules predicting every output each cycle.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;
   localparam int NUM   = 2;
   localparam int SIZE  = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_port_arbiter_if #(.NUM(NUM), .SIZE(SIZE), .DEPTH(DEPTH)) bus ();

   ram_port_arbiter #(.NUM(NUM), .SIZE(SIZE), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // behavioural RAM: registered read, read-before-write
   logic [SIZE-1:0] ram_arr [DEPTH];
   always @(posedge clk) begin
      if (bus.ram_write_en) ram_arr[bus.ram_waddr] <= bus.ram_write_data;
      bus.ram_read_data <= ram_arr[bus.ram_raddr];
   end

   int total = 0;
   int bad   = 0;

   // reference model state
   int              m_wptr, m_rptr, m_rid, m_cc;
   bit              m_pend;
   logic [SIZE-1:0] m_mem [DEPTH];
   logic [SIZE-1:0] m_rexp;

   // per-cycle predictions
   int              e_w, e_r;
   int              e_wa, e_ra;
   logic [SIZE-1:0] e_wd;
   bit              e_coll;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [NUM-1:0] req, input int ptr);
      for (int k = 0; k < NUM; k++) begin
         automatic int i = (ptr + k) % NUM;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   task automatic predict();
      e_w    = pick(bus.wr_req, m_wptr);
      e_r    = pick(bus.rd_req, m_rptr);
      e_wa   = (e_w >= 0) ? int'(bus.wr_addr[e_w*AW +: AW]) : 0;
      e_wd   = (e_w >= 0) ? bus.wr_data[e_w*SIZE +: SIZE] : '0;
      e_ra   = (e_r >= 0) ? int'(bus.rd_addr[e_r*AW +: AW]) : 0;
      e_coll = (e_w >= 0) && (e_r >= 0) && (e_ra == e_wa);
   endtask

   task automatic check_all();
      predict();
      chk("wr_ack",         bus.wr_ack,         (e_w >= 0) ? (32'd1 << e_w) : 32'd0);
      chk("ram_write_en",   bus.ram_write_en,   (e_w >= 0) ? 32'd1 : 32'd0);
      chk("ram_waddr",      bus.ram_waddr,      e_wa);
      chk("ram_write_data", bus.ram_write_data, e_wd);
      chk("ram_raddr",      bus.ram_raddr,      e_ra);
      chk("rd_ack",         bus.rd_ack,         (e_r >= 0 && !e_coll) ? (32'd1 << e_r) : 32'd0);
      chk("rd_valid",       bus.rd_valid,       m_pend ? (32'd1 << m_rid) : 32'd0);
      if (m_pend) chk("rd_data", bus.rd_data, m_rexp);
      chk("conflict_cnt",   bus.conflict_cnt,   m_cc);
   endtask

   // one clock: settle, check, advance model across the edge
   task automatic step();
      #1;
      check_all();
      @(posedge clk);
      if (e_r >= 0 && !e_coll) begin
         m_rexp = m_mem[e_ra];
         m_pend = 1'b1;
         m_rid  = e_r;
         m_rptr = (e_r + 1) % NUM;
      end else begin
         m_pend = 1'b0;
      end
      if (e_coll) m_cc = (m_cc < 255) ? m_cc + 1 : 255;
      if (e_w >= 0) begin
         m_mem[e_wa] = e_wd;
         m_wptr      = (e_w + 1) % NUM;
      end
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      m_wptr = 0; m_rptr = 0; m_rid = 0; m_cc = 0; m_pend = 1'b0;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_wr(input logic [NUM-1:0] req, input int a0, input int d0, input int a1, input int d1);
      bus.wr_req  = req;
      bus.wr_addr = {AW'(a1), AW'(a0)};
      bus.wr_data = {SIZE'(d1), SIZE'(d0)};
   endtask

   task automatic set_rd(input logic [NUM-1:0] req, input int a0, input int a1);
      bus.rd_req  = req;
      bus.rd_addr = {AW'(a1), AW'(a0)};
   endtask

   logic [NUM-1:0] seq [4];

   initial begin
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
      set_wr('0, 0, 0, 0, 0);
      set_rd('0, 0, 0);

      // reset, then idle
      apply_reset();
      #1;
      chk("idle_wr_ack", bus.wr_ack, 0);
      chk("idle_rd_ack", bus.rd_ack, 0);
      chk("idle_rd_valid", bus.rd_valid, 0);
      chk("idle_wen", bus.ram_write_en, 0);
      chk("idle_cc", bus.conflict_cnt, 0);
      step();
      step();

      // fill every RAM word so later reads are defined
      for (int a = 0; a < DEPTH; a++) begin
         set_wr(2'b01, a, a * 17 + 3, 0, 0);
         step();
      end
      set_wr('0, 0, 0, 0, 0);
      step();

      // write fairness from a fresh pointer
      apply_reset();
      set_wr(2'b11, 1, 8'h11, 2, 8'h22);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("fair_wr_ack", bus.wr_ack, seq[k]);
         step();
      end
      set_wr('0, 0, 0, 0, 0);

      // read fairness
      set_rd(2'b11, 6, 7);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("fair_rd_ack", bus.rd_ack, seq[k]);
         step();
      end
      set_rd('0, 0, 0);
      step();

      // write then read back through the other requester
      set_wr(2'b01, 3, 8'hA5, 0, 0);
      step();
      set_wr('0, 0, 0, 0, 0);
      set_rd(2'b10, 0, 3);
      #1;
      chk("wtr_rd_ack", bus.rd_ack, 2'b10);
      step();
      set_rd('0, 0, 0);
      #1;
      chk("wtr_rd_valid", bus.rd_valid, 2'b10);
      chk("wtr_rd_data", bus.rd_data, 8'hA5);
      step();

      // collision then retry
      set_wr(2'b01, 5, 8'h5C, 0, 0);
      set_rd(2'b10, 0, 5);
      #1;
      chk("coll_rd_ack", bus.rd_ack, 0);
      step();
      chk("coll_cc", bus.conflict_cnt, 1);
      set_wr('0, 0, 0, 0, 0);
      #1;
      chk("retry_rd_ack", bus.rd_ack, 2'b10);
      step();
      set_rd('0, 0, 0);
      #1;
      chk("retry_rd_valid", bus.rd_valid, 2'b10);
      chk("retry_rd_data", bus.rd_data, 8'h5C);
      step();

      // conflict counter saturation
      set_wr(2'b01, 5, 8'h77, 0, 0);
      set_rd(2'b10, 0, 5);
      for (int k = 0; k < 300; k++) step();
      chk("sat_cc", bus.conflict_cnt, 255);
      set_wr('0, 0, 0, 0, 0);
      set_rd('0, 0, 0);
      step();

      // random traffic against the model
      for (int k = 0; k < 400; k++) begin
         bus.wr_req  = NUM'($urandom_range(0, 3));
         bus.wr_addr = (NUM*AW)'($urandom);
         bus.wr_data = (NUM*SIZE)'($urandom);
         bus.rd_req  = NUM'($urandom_range(0, 3));
         bus.rd_addr = (NUM*AW)'($urandom);
         step();
      end
      set_wr('0, 0, 0, 0, 0);
      set_rd('0, 0, 0);
      step();

      // same requester reads and writes different addresses together
      set_wr(2'b01, 1, 8'h3C, 0, 0);
      set_rd(2'b01, 2, 0);
      #1;
      chk("dual_wr_ack", bus.wr_ack, 2'b01);
      chk("dual_rd_ack", bus.rd_ack, 2'b01);
      step();
      set_wr('0, 0, 0, 0, 0);
      set_rd('0, 0, 0);
      step();

      // reset in the cycle after a read ack drops the return
      set_rd(2'b01, 4, 0);
      #1;
      chk("mid_rd_ack", bus.rd_ack, 2'b01);
      step();
      set_rd('0, 0, 0);
      #1;
      chk("mid_pre_valid", bus.rd_valid, 2'b01);
      apply_reset();
      chk("mid_rd_valid", bus.rd_valid, 0);
      chk("mid_cc", bus.conflict_cnt, 0);
      set_wr(2'b11, 0, 8'h01, 7, 8'h02);
      #1;
      chk("post_rst_wr_ack", bus.wr_ack, 2'b01);
      step();
      step();
      set_wr('0, 0, 0, 0, 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
